// File: rtl/i2c_traffic_gen.sv
// I2C traffic generator/self-checker: alternates write/read per slave, counts pass/fail.
// Latency: GAP_CYCLES idle clocks, then ISSUE until ack, wait for m_ready, one CHECK clock.
// Backpressure: waits indefinitely on ack/ready unless I2C_TGEN_TIMEOUT_EN adds a watchdog.
module i2c_traffic_gen #(
    parameter int               NUM_SLAVES     = 2,
    parameter logic [6:0]       BASE_ADDR      = 7'h50,
    parameter int               DATA_W         = 8,
    parameter logic [DATA_W-1:0] INIT_M_DATA   = 'hFE,
    parameter logic [DATA_W-1:0] INIT_S_DATA   = 'hCC,
    parameter int               GAP_CYCLES     = 16,
    parameter int               MCLK_DIV       = 2,
    parameter int               TIMEOUT_CYCLES = 4096
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    output logic                         m_clock,
    output logic                         m_reset,
    output logic [NUM_SLAVES-1:0]        s_reset,
    output logic                         m_enable,
    output logic                         m_rw,
    output logic                         m_restart,
    output logic [6:0]                   address,
    output logic [DATA_W-1:0]            m_tx_data,
    output logic [NUM_SLAVES*DATA_W-1:0] s_tx_data,
    input  logic                         m_ack,
    input  logic                         m_ready,
    input  logic [DATA_W-1:0]            m_rx_data,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rx_data,
    output logic [15:0]                  pass_cnt,
    output logic [15:0]                  fail_cnt,
    output logic                         busy,
    output logic                         timeout
);

    localparam logic [1:0] ST_GAP   = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_CHECK = 2'd3;

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int DIV_W = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;

    logic [1:0]        state;
    logic [GAP_W-1:0]  gap_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [SEL_W-1:0]  sel;
    logic              ack_seen;
    logic [DATA_W-1:0] cur_s_rx;
    logic [DATA_W-1:0] cur_s_tx;
    logic              check_ok;

    assign m_enable  = (state == ST_ISSUE);
    assign busy      = (state != ST_GAP);
    assign m_restart = 1'b0;
    assign address   = BASE_ADDR + 7'(sel);

    assign cur_s_rx = s_rx_data[int'(sel)*DATA_W +: DATA_W];
    assign cur_s_tx = s_tx_data[int'(sel)*DATA_W +: DATA_W];

`ifdef I2C_TGEN_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            to_flag;

    // A watchdog expiry forces the transfer to be scored as a failure.
    assign check_ok = !to_flag && (m_rw ? (m_rx_data == cur_s_tx) : (cur_s_rx == m_tx_data));
`else
    assign check_ok = m_rw ? (m_rx_data == cur_s_tx) : (cur_s_rx == m_tx_data);
    assign timeout  = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_GAP;
            gap_cnt   <= '0;
            div_cnt   <= '0;
            sel       <= '0;
            ack_seen  <= 1'b0;
            m_rw      <= 1'b0;
            m_clock   <= 1'b0;
            m_reset   <= 1'b0;
            s_reset   <= '0;
            m_tx_data <= INIT_M_DATA;
            for (int j = 0; j < NUM_SLAVES; j++)
                s_tx_data[j*DATA_W +: DATA_W] <= INIT_S_DATA + DATA_W'(j);
            pass_cnt  <= '0;
            fail_cnt  <= '0;
`ifdef I2C_TGEN_TIMEOUT_EN
            wd_cnt    <= '0;
            to_flag   <= 1'b0;
            timeout   <= 1'b0;
`endif
        end else begin
            m_reset <= 1'b1;
            s_reset <= '1;

            if (div_cnt == DIV_W'(MCLK_DIV - 1)) begin
                div_cnt <= '0;
                m_clock <= ~m_clock;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            case (state)
                ST_GAP: begin
                    if (!start) begin
                        gap_cnt <= '0;
                    end else if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        gap_cnt  <= '0;
                        ack_seen <= 1'b0;
                        state    <= ST_ISSUE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    // Leave only once the ack strobe has been seen and dropped again.
                    if (ack_seen && !m_ack) begin
                        ack_seen <= 1'b0;
                        state    <= ST_WAIT;
                    end else if (m_ack) begin
                        ack_seen <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (m_ready)
                        state <= ST_CHECK;
                end
                default: begin
                    if (check_ok) begin
                        if (pass_cnt != 16'hFFFF)
                            pass_cnt <= pass_cnt + 1'b1;
                    end else if (fail_cnt != 16'hFFFF) begin
                        fail_cnt <= fail_cnt + 1'b1;
                    end
                    if (!m_rw) begin
                        for (int j = 0; j < NUM_SLAVES; j++)
                            s_tx_data[j*DATA_W +: DATA_W] <= s_tx_data[j*DATA_W +: DATA_W] + 1'b1;
                        m_rw <= 1'b1;
                    end else begin
                        m_tx_data <= m_tx_data + 1'b1;
                        m_rw      <= 1'b0;
                        sel       <= (sel == SEL_W'(NUM_SLAVES - 1)) ? '0 : sel + 1'b1;
                    end
                    gap_cnt <= '0;
                    state   <= ST_GAP;
                end
            endcase

`ifdef I2C_TGEN_TIMEOUT_EN
            if (state == ST_GAP) begin
                wd_cnt <= '0;
            end else if (state == ST_ISSUE || state == ST_WAIT) begin
                // Expiry takes priority over any normal transition on the same clock.
                if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state    <= ST_CHECK;
                    ack_seen <= 1'b0;
                    to_flag  <= 1'b1;
                    timeout  <= 1'b1;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end else begin
                to_flag <= 1'b0;
            end
`endif
        end
    end

endmodule
